// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the 2-way set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_WT_REQ,
    S_RESP
  } state_t;

  function automatic int tag_w(input int index_w, input int offset_w);
    return 30 - index_w - offset_w;
  endfunction

  function automatic int index_lsb(input int offset_w);
    return offset_w + 2;
  endfunction

  function automatic int tag_lsb(input int index_w, input int offset_w);
    return index_w + offset_w + 2;
  endfunction

  function automatic int block_w(input int offset_w);
    return 32 << offset_w;
  endfunction

endpackage

// File: rtl/sa_cache_way.sv
// One cache way: per-set valid bit, tag and data block, with tag compare on the addressed set.
module sa_cache_way
  import cache_pkg::*;
#(
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 1,
  parameter int TAG_W    = 19
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [INDEX_W-1:0]          index,
  input  logic [OFFSET_W-1:0]         offset,
  input  logic [TAG_W-1:0]            tag,
  input  logic                        fill_en,
  input  logic [32*(2**OFFSET_W)-1:0] fill_data,
  input  logic                        word_we,
  input  logic [31:0]                 word_wdata,
  output logic                        valid,
  output logic                        hit,
  output logic [31:0]                 word
);

  localparam int SETS  = 2**INDEX_W;
  localparam int BLK_W = block_w(OFFSET_W);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0] data_q [SETS];

  assign valid = valid_q[index];
  assign hit   = valid && (tag_q[index] == tag);
  assign word  = data_q[index][{offset, 5'b0} +: 32];

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone decide residency.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= fill_data;
    end else if (word_we) begin
      data_q[index][{offset, 5'b0} +: 32] <= word_wdata;
    end
  end

endmodule

// File: rtl/sa_cache.sv
// 2-way set-associative write-through, no-write-allocate cache with LRU victim selection.
module sa_cache
  import cache_pkg::*;
#(
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 1,
  parameter int WRITE_EN = 1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [31:0]                 mem_req_addr,
  output logic [31:0]                 mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [32*(2**OFFSET_W)-1:0] mem_resp_data
);

  localparam int TAG_W   = tag_w(INDEX_W, OFFSET_W);
  localparam int IDX_LSB = index_lsb(OFFSET_W);
  localparam int TAG_LSB = tag_lsb(INDEX_W, OFFSET_W);
  localparam int SETS    = 2**INDEX_W;

  state_t              state;
  logic [31:2]         addr_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [SETS-1:0]     lru;

  logic [OFFSET_W-1:0] off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          hit;
  logic [1:0]          vld;
  logic [31:0]         way_word [2];
  logic [1:0]          fill_en;
  logic [1:0]          word_we;
  logic                victim;
  logic                flush_now;
  logic [31:0]         hit_word;
  logic [31:0]         fill_word;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  assign off       = addr_q[IDX_LSB-1:2];
  assign idx       = addr_q[TAG_LSB-1:IDX_LSB];
  assign tag       = addr_q[31:TAG_LSB];
  assign flush_now = (state == S_IDLE) && flush;
  assign req_ready = (state == S_IDLE) && !flush;
  assign hit_word  = hit[1] ? way_word[1] : way_word[0];
  assign fill_word = mem_resp_data[{off, 5'b0} +: 32];

  always_comb begin
    victim  = !vld[0] ? 1'b0 : (!vld[1] ? 1'b1 : lru[idx]);
    fill_en = '0;
    word_we = '0;
    if (state == S_FILL_WAIT && mem_resp_valid) fill_en[victim] = 1'b1;
    if (state == S_LOOKUP && we_q)              word_we = hit;
  end

  sa_cache_way #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) u_way0 (
    .CLK(CLK), .reset(reset), .clear(flush_now),
    .index(idx), .offset(off), .tag(tag),
    .fill_en(fill_en[0]), .fill_data(mem_resp_data),
    .word_we(word_we[0]), .word_wdata(wdata_q),
    .valid(vld[0]), .hit(hit[0]), .word(way_word[0])
  );

  sa_cache_way #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) u_way1 (
    .CLK(CLK), .reset(reset), .clear(flush_now),
    .index(idx), .offset(off), .tag(tag),
    .fill_en(fill_en[1]), .fill_data(mem_resp_data),
    .word_we(word_we[1]), .word_wdata(wdata_q),
    .valid(vld[1]), .hit(hit[1]), .word(way_word[1])
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= S_IDLE;
      lru           <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            lru <= '0;
          end else if (req_valid) begin
            addr_q  <= req_addr[31:2];
            we_q    <= (WRITE_EN != 0) && req_we;
            wdata_q <= req_wdata;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (|hit) lru[idx] <= ~hit[1];
          if (we_q) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {addr_q, 2'b00};
            mem_req_wdata <= wdata_q;
            state         <= S_WT_REQ;
          end else if (|hit) begin
            rdata_q <= hit_word;
            state   <= S_RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
            state         <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            lru[idx] <= ~victim;
            rdata_q  <= fill_word;
            state    <= S_RESP;
          end
        end
        S_WT_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            rdata_q       <= '0;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= rdata_q;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache.sv
// Randomized self-checking bench for sa_cache against a recency-list cache model and a backing-store memory.
module tb_sa_cache;

  logic        CLK = 1'b0;
  logic        reset, req_valid, req_ready, req_we, flush;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  sa_cache #(.INDEX_W(10), .OFFSET_W(1), .WRITE_EN(1)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Backing memory: unwritten words read back as a fixed scramble of their address.
  logic [31:0] mem_st [logic [31:0]];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem_st.exists(a)) return mem_st[a];
    return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  // Cache model: per set, resident tags ordered least- to most-recently used.
  logic [18:0] rtag [1024][2];
  int          rcnt [1024];

  task automatic model_reset();
    for (int unsigned s = 0; s < 1024; s++) rcnt[s] = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit we, output bit hit);
    int unsigned ix;
    logic [18:0] tg;
    int          pos;
    ix  = a[12:3];
    tg  = a[31:13];
    pos = -1;
    for (int i = 0; i < rcnt[ix]; i++) if (rtag[ix][i] == tg) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      if (pos == 0 && rcnt[ix] == 2) begin
        rtag[ix][0] = rtag[ix][1];
        rtag[ix][1] = tg;
      end
    end else if (!we) begin
      if (rcnt[ix] < 2) begin
        rtag[ix][rcnt[ix]] = tg;
        rcnt[ix]++;
      end else begin
        rtag[ix][0] = rtag[ix][1];
        rtag[ix][1] = tg;
      end
    end
  endtask

  typedef struct {
    bit          we;
    bit          hit;
    logic [31:0] rdata;
    int          acc;
    int          rd_base;
    int          wr_base;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          resp_cnt = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = '0;

  // Memory agent state
  int          n_rd_hs = 0;
  int          n_wr_hs = 0;
  int          pend = 0;
  logic [31:0] pend_addr = '0;
  int          force_delay = 0;
  int          hold_low = 0;
  bit          rnd_ready = 1'b1;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] exp_mem_addr = '0;
  logic [31:0] exp_mem_wdata = '0;
  logic        exp_mem_we = 1'b0;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge CLK);
      mem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = {memword(pend_addr + 32'd4), memword(pend_addr)};
        end
      end
      if (stall_prev && !reset) begin
        chk("mem_req_valid_held", {31'd0, mem_req_valid}, 32'd1);
        chk("mem_req_addr_stable", mem_req_addr, prev_addr);
      end
      if (mem_req_valid && hold_low > 0) begin
        mem_req_ready = 1'b0;
        hold_low--;
      end else begin
        mem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      stall_prev = mem_req_valid && !mem_req_ready && !reset;
      prev_addr  = mem_req_addr;
      if (mem_req_valid && mem_req_ready && !reset) begin
        chk("mem_req_we", {31'd0, mem_req_we}, {31'd0, exp_mem_we});
        chk("mem_req_addr", mem_req_addr, exp_mem_addr);
        if (mem_req_we) begin
          n_wr_hs++;
          chk("mem_req_wdata", mem_req_wdata, exp_mem_wdata);
          mem_st[mem_req_addr] = mem_req_wdata;
        end else begin
          n_rd_hs++;
          last_rd_addr = mem_req_addr;
          pend_addr    = mem_req_addr;
          pend         = (force_delay > 0) ? force_delay : $urandom_range(1, 3);
        end
      end
    end
  end

  // Response checker: every resp_valid cycle is matched against the oldest expected response.
  always @(negedge CLK) begin
    if (!reset && resp_valid) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=resp_valid=1 required=no response (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("fill_count", n_rd_hs - mon_e.rd_base, (mon_e.hit || mon_e.we) ? 32'd0 : 32'd1);
        chk("write_count", n_wr_hs - mon_e.wr_base, mon_e.we ? 32'd1 : 32'd0);
        last_lat = cyc - mon_e.acc;
        if (!mon_e.we && mon_e.hit) chk("hit_latency", last_lat, 32'd2);
        last_rdata = resp_rdata;
      end
      resp_cnt++;
    end
  end

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lit_hit);
    int   n;
    bit   hit;
    exp_t e;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    model_access(a, we, hit);
    if (lit_hit >= 0) chk("model_hit", {31'd0, hit}, lit_hit);
    e.we      = we;
    e.hit     = hit;
    e.rdata   = we ? 32'd0 : memword({a[31:2], 2'b00});
    e.acc     = cyc + 1;
    e.rd_base = n_rd_hs;
    e.wr_base = n_wr_hs;
    expq.push_back(e);
    exp_mem_we    = we;
    exp_mem_addr  = we ? {a[31:2], 2'b00} : {a[31:3], 3'b000};
    exp_mem_wdata = wd;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lit_hit);
    int target, n;
    target = resp_cnt + 1;
    issue(we, a, wd, lit_hit);
    n = 0;
    while (resp_cnt < target && n < 200) begin
      step();
      n++;
    end
    if (resp_cnt < target) begin
      chk("resp_timeout", resp_cnt, target);
      expq.delete();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [31:0] a;
    int unsigned tg, ix;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_we", {31'd0, mem_req_we}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);

    mem_st[32'h0000_2008] = 32'h2222_2222;
    mem_st[32'h0000_200C] = 32'h1111_1111;
    do_req(1'b0, 32'h0000_2008, 32'd0, 0);
    chk("cold_fill_addr", last_rd_addr, 32'h0000_2008);
    chk("cold_rdata", last_rdata, 32'h2222_2222);
    do_req(1'b0, 32'h0000_200C, 32'd0, 1);
    chk("reread_rdata", last_rdata, 32'h1111_1111);
    chk("reread_latency", last_lat, 32'd2);

    do_req(1'b0, 32'h0000_2008, 32'd0, 1);
    do_req(1'b0, 32'h0000_4008, 32'd0, 0);
    do_req(1'b0, 32'h0000_2008, 32'd0, 1);
    do_req(1'b0, 32'h0000_6008, 32'd0, 0);
    do_req(1'b0, 32'h0000_2008, 32'd0, 1);
    do_req(1'b0, 32'h0000_4008, 32'd0, 0);
    chk("evict_fill_addr", last_rd_addr, 32'h0000_4008);

    rnd_ready = 1'b0;
    hold_low  = 3;
    do_req(1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 1);
    chk("wt_stall_latency", last_lat, 32'd6);
    rnd_ready = 1'b1;
    do_req(1'b0, 32'h0000_2008, 32'd0, 1);
    chk("read_after_write", last_rdata, 32'hDEAD_BEEF);

    do_flush();
    do_req(1'b0, 32'h0000_2008, 32'd0, 0);

    force_delay = 6;
    base = n_rd_hs;
    issue(1'b0, 32'h0000_2010, 32'd0, 0);
    n = 0;
    while (n_rd_hs == base && n < 50) begin
      step();
      n++;
    end
    chk("fill_handshake_seen", n_rd_hs - base, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expq.delete();
    model_reset();
    chk("abort_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (8) step();
    force_delay = 0;
    do_req(1'b0, 32'h0000_2010, 32'd0, 0);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      tg = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0: ix = 0;
        1: ix = 1;
        2: ix = 2;
        default: ix = 1023;
      endcase
      a = (tg << 13) | (ix << 3) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      do_req($urandom_range(0, 9) < 3, a, $urandom, -1);
    end

    repeat (4) step();
    chk("responses_outstanding", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
